// File: rtl/rr_arb8.sv
// Eight-way round-robin arbiter with a bounded grant hold time.
// All outputs are registered from the next-state values, so they change on the deciding edge.
module rr_arb8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [7:0] i_req,
   output logic [7:0] o_gnt,
   output logic [2:0] o_gnt_idx,
   output logic       o_gnt_vld,
   output logic       o_timeout
);

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] gnt_idx_q, gnt_idx_d;
   logic       gnt_vld_q, gnt_vld_d;
   logic       timeout_q, timeout_d;

   logic [15:0] req_dbl_s;
   logic [7:0]  req_rot_s;
   logic [2:0]  pick_off_s;
   logic        pick_any_s;

   // Rotate requests so bit 0 is the pointer position, then find the lowest set offset
   always_comb begin
      req_dbl_s  = {i_req, i_req} >> ptr_q;
      req_rot_s  = req_dbl_s[7:0];
      pick_any_s = |req_rot_s;
      pick_off_s = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (req_rot_s[k]) begin
            pick_off_s = k[2:0];
         end else begin
            pick_off_s = pick_off_s;
         end
      end
   end

   // Next-state logic; release priority is enable, then request drop, then hold limit
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_en && pick_any_s) begin
               idx_d   = ptr_q + pick_off_s;
               cnt_d   = 8'd0;
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!i_en || !i_req[idx_q]) begin
               ptr_d   = idx_q + 3'd1;
               state_d = ST_IDLE;
            end else if (cnt_q == HOLD_LAST) begin
               ptr_d     = idx_q + 3'd1;
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values derived from the state about to be entered
   always_comb begin
      gnt_vld_d = (state_d == ST_GRANT);
      if (gnt_vld_d) begin
         gnt_d     = 8'd1 << idx_d;
         gnt_idx_d = idx_d;
      end else begin
         gnt_d     = 8'd0;
         gnt_idx_d = 3'd0;
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'd0;
         idx_q     <= 3'd0;
         cnt_q     <= 8'd0;
         gnt_q     <= 8'd0;
         gnt_idx_q <= 3'd0;
         gnt_vld_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
         gnt_vld_q <= gnt_vld_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_gnt     = gnt_q;
   assign o_gnt_idx = gnt_idx_q;
   assign o_gnt_vld = gnt_vld_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8: four instances with different hold limits share one stimulus.
// Each observation is packed as {timeout, vld, idx[2:0], gnt[7:0]}.
module tb_rr_arb8;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;

   logic [7:0] gnt16, gnt4, gnt3, gnt1;
   logic [2:0] idx16, idx4, idx3, idx1;
   logic       vld16, vld4, vld3, vld1;
   logic       to16, to4, to3, to1;

   int n_checks = 0;
   int n_errors = 0;

   rr_arb8 #(.MAX_HOLD(16)) u_arb16 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req),
      .o_gnt(gnt16), .o_gnt_idx(idx16), .o_gnt_vld(vld16), .o_timeout(to16));
   rr_arb8 #(.MAX_HOLD(4)) u_arb4 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req),
      .o_gnt(gnt4), .o_gnt_idx(idx4), .o_gnt_vld(vld4), .o_timeout(to4));
   rr_arb8 #(.MAX_HOLD(3)) u_arb3 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req),
      .o_gnt(gnt3), .o_gnt_idx(idx3), .o_gnt_vld(vld3), .o_timeout(to3));
   rr_arb8 #(.MAX_HOLD(1)) u_arb1 (.i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req(req),
      .o_gnt(gnt1), .o_gnt_idx(idx1), .o_gnt_vld(vld1), .o_timeout(to1));

   logic [12:0] s16, s4, s3, s1;
   assign s16 = {to16, vld16, idx16, gnt16};
   assign s4  = {to4, vld4, idx4, gnt4};
   assign s3  = {to3, vld3, idx3, gnt3};
   assign s1  = {to1, vld1, idx1, gnt1};

   localparam logic [12:0] NONE = 13'h0000;
   localparam logic [12:0] TOUT = 13'h1000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] g(input int k);
      logic [2:0] i3;
      logic [7:0] one;
      i3  = k[2:0];
      one = 8'd1;
      return {1'b0, 1'b1, i3, one << i3};
   endfunction

   task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %04h expected %04h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 8'h00;
      #12;
      check("reset_state", s16, NONE);
      rst_n = 1'b1;

      // Mid-grant asynchronous reset restarts the pointer at 0
      en  = 1'b1;
      req = 8'hFF;
      tick(); check("rst_g0", s16, g(0));
      req = 8'hFE;
      tick(); check("rst_rel0", s16, NONE);
      req = 8'hFF;
      tick(); check("rst_g1", s16, g(1));
      #2 rst_n = 1'b0;
      #1 check("rst_async", s16, NONE);
      check("rst_async_h4", s4, NONE);
      rst_n = 1'b1;
      tick(); check("rst_first_g0", s16, g(0));

      // Single requester, then pointer lands on 4
      do_reset();
      en  = 1'b1;
      req = 8'h08;
      for (int i = 0; i < 5; i++) begin
         tick(); check("single_g3", s16, g(3));
      end
      req = 8'h00;
      tick(); check("single_rel", s16, NONE);
      req = 8'h11;
      tick(); check("single_ptr4", s16, g(4));

      // Rotation with two-cycle grants and one-cycle gaps
      do_reset();
      en  = 1'b1;
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick(); check("rot_a", s16, g(i % 8));
         tick(); check("rot_b", s16, g(i % 8));
         req = 8'hFF & ~(8'h01 << (i % 8));
         tick(); check("rot_gap", s16, NONE);
         req = 8'hFF;
      end

      // Hold-limit timeout with wrap from 7 back to 0
      do_reset();
      en  = 1'b1;
      req = 8'h81;
      for (int i = 0; i < 4; i++) begin
         tick(); check("to_g0", s4, g(0));
      end
      tick(); check("to_pulse0", s4, TOUT);
      for (int i = 0; i < 4; i++) begin
         tick(); check("to_g7", s4, g(7));
      end
      tick(); check("to_pulse7", s4, TOUT);
      tick(); check("to_wrap_g0", s4, g(0));

      // Enable drop on idx 5 at cnt 2
      do_reset();
      en  = 1'b1;
      req = 8'h20;
      for (int i = 0; i < 3; i++) begin
         tick(); check("en_g5", s16, g(5));
      end
      en = 1'b0;
      tick(); check("en_rel", s16, NONE);
      tick(); check("en_blocked", s16, NONE);
      tick(); check("en_blocked2", s16, NONE);
      en = 1'b1;
      tick(); check("en_regrant5", s16, g(5));

      // Request drop coincides with the hold limit; single-cycle grants at limit 1
      do_reset();
      en  = 1'b1;
      req = 8'h01;
      tick(); check("drop_g0_a", s3, g(0)); check("h1_g0_a", s1, g(0));
      tick(); check("drop_g0_b", s3, g(0)); check("h1_pulse", s1, TOUT);
      tick(); check("drop_g0_c", s3, g(0)); check("h1_g0_b", s1, g(0));
      req = 8'h00;
      tick(); check("drop_no_to", s3, NONE); check("h1_drop", s1, NONE);
      tick(); check("drop_idle", s3, NONE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Round-robin arbiter that shares one downstream resource among eight requesters. It grants one requester at a time and holds the grant while that requester keeps its request asserted, up to a bounded number of cycles. It then rotates priority so every requester is served. The 3-bit grant index is the same encoding used by the team's 8-to-3 encoder/seven-segment path, so `o_gnt_idx` can drive the digit display directly for debug.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles one grant may be held; legal range 1..255.
- `i_clk`  input  1  rising-edge clock.
- `i_rst_n`  input  1  asynchronous, active-low reset.
- `i_en`  input  1  arbiter enable; low blocks new grants and releases any current grant.
- `i_req`  input  8  request vector; bit k = requester k.
- `o_gnt`  output  8  one-hot grant (all zero when no grant).
- `o_gnt_idx`  output  3  index of granted requester (0 when no grant).
- `o_gnt_vld`  output  1  a grant is active.
- `o_timeout`  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- All outputs are registered.
- Internal state:
  - FSM with states IDLE and GRANT.
  - 3-bit rotation pointer `ptr`.
  - 8-bit hold counter `cnt`.
  - 3-bit current index `idx`.
- Reset values:
  - FSM = IDLE, `ptr` = 0, `cnt` = 0, `idx` = 0.
  - `o_gnt` = 8'h00, `o_gnt_idx` = 0, `o_gnt_vld` = 0, `o_timeout` = 0.
- IDLE:
  - If `i_en` = 1 and `i_req` != 0, select the first set bit searching `ptr`, `ptr`+1, … , `ptr`+7, modulo 8.
  - Load that index into `idx`, clear `cnt` to 0, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT: `o_gnt_vld` = 1, `o_gnt` = 1 << `idx`, `o_gnt_idx` = `idx`. `cnt` increments each GRANT cycle. Release conditions, checked each cycle in this priority:
  1. `i_en` = 0: release, no timeout pulse.
  2. `i_req[idx]` = 0: release, no timeout pulse.
  3. `cnt` = `MAX_HOLD`-1: release and pulse `o_timeout`.
  - If none holds, stay in GRANT.
- On any release:
  - `ptr` ← (`idx`+1) mod 8, wrapping from 7 to 0.
  - Go to IDLE; outputs clear on the next edge.
- Requests from non-granted requesters never preempt an active grant.
- `i_req` changes on other bits during GRANT are ignored until the next IDLE.
- Reset asserted at any time, including mid-grant: all state and outputs go to reset values immediately (asynchronous). `ptr` restarts at 0.

## Timing
- Grant latency: a request first sampled high at edge n in IDLE gives `o_gnt_vld` = 1 after edge n.
- Release latency: a release condition sampled at edge m drops `o_gnt_vld` after edge m.
- After every release there is exactly one IDLE cycle with no grant before the next grant. Minimum gap between two grants is therefore 1 cycle.
- Hold limit: with the request held continuously, a grant stays visible for exactly `MAX_HOLD` cycles.
- `o_timeout` is high for exactly one cycle: the first cycle in which `o_gnt_vld` is 0 after a limit release.
- `MAX_HOLD` = 1 gives single-cycle grants, each followed by a `o_timeout` pulse whenever the request is still held.
- If a request drops in the same cycle that `cnt` reaches `MAX_HOLD`-1, the request-drop rule wins and no timeout is reported.

## Test plan
- Reset: assert `i_rst_n` = 0 mid-simulation with `i_req` = 8'hFF → all outputs 0 asynchronously. After release, the first grant is to index 0.
- Single requester: `i_req` = 8'h08 for 5 cycles, then 0 (`MAX_HOLD` = 16) → `o_gnt` = 8'h08 and `o_gnt_idx` = 3 for 5 cycles, then 0. `o_timeout` stays 0 and `ptr` becomes 4.
- Rotation: `i_req` = 8'hFF, each granted requester drops its bit after 2 cycles and reasserts it later → grant order 0,1,2,…,7,0. Each grant lasts 2 cycles with a 1-cycle gap between grants.
- Timeout: `MAX_HOLD` = 4, `i_req` = 8'h81 held constant → idx 0 granted for 4 cycles, then `o_timeout` pulses, then idx 7 for 4 cycles, then `o_timeout` pulses, then idx 0 (wrap).
- Enable drop: grant active on idx 5 at `cnt` = 2, drive `i_en` = 0 → grant clears next cycle with `o_timeout` = 0. No new grant while `i_en` = 0. After `i_en` = 1 with `i_req` = 8'h20, idx 5 is granted again.
- Simultaneous drop and limit: `MAX_HOLD` = 3, drop `i_req[idx]` in the cycle `cnt` = 2 → grant lasts 3 cycles and `o_timeout` stays 0.
